accumulator_array: RTL

// - Parametrised successor to the fixed 128x32 accumulator; holds systolic-array partial sums between MAC passes.
// - Registered read port: NORMAL (row) or DIAGONAL (skewed) mode. Write port does overwrite or read-modify-write add.
// - Self-clearing FSM zeroes storage after reset or on request.
// - Sits between the MAC array column outputs and the activation/unified-buffer write-back path.

---
 rtl/accumulator_array.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/accumulator_array.sv
// Partial-sum store between MAC columns and write-back; build with ACC_SATURATE_EN for saturating accumulate.
// Latency: writes commit in one cycle; reads are registered, data and rd_valid_o one cycle after rd_en_i.
// Backpressure: ready_o low during the DEPTH-cycle zero sweep; rd/wr/clear requests then are dropped.
module accumulator_array #(
    parameter int NUM_COLS = 32,
    parameter int DEPTH    = 128,
    parameter int IN_W     = 32,
    parameter int ACC_W    = 32,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    output logic                      ready_o,
    input  logic                      wr_en_i,
    input  logic                      wr_acc_i,
    input  logic [AW-1:0]             wr_addr_i,
    input  logic [NUM_COLS*IN_W-1:0]  wr_data_i,
    input  logic                      rd_en_i,
    input  logic                      rd_mode_i,
    input  logic [AW-1:0]             rd_addr_i,
    output logic [NUM_COLS*ACC_W-1:0] rd_data_o,
    output logic                      rd_valid_o,
    output logic                      sat_o
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           clr_ptr_q, clr_ptr_d;
    logic signed [ACC_W-1:0] mem [DEPTH][NUM_COLS];
    logic signed [ACC_W-1:0] lane_nxt [NUM_COLS];
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    clear_fire;
    logic                    rd_valid_q;

    assign ready_o    = (state_q == IDLE);
    assign wr_fire    = ready_o & wr_en_i;
    assign rd_fire    = ready_o & rd_en_i;
    assign clear_fire = ready_o & clear_i;
    assign rd_valid_o = rd_valid_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            CLEAR: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear_i) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // Storage has no reset of its own; the sweep that follows reset zeroes it.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (state_q == CLEAR) begin
                for (int k = 0; k < NUM_COLS; k++) begin
                    mem[clr_ptr_q][k] <= '0;
                end
            end else if (wr_fire) begin
                for (int k = 0; k < NUM_COLS; k++) begin
                    mem[wr_addr_i][k] <= lane_nxt[k];
                end
            end
        end
    end

`ifdef ACC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [NUM_COLS-1:0] lane_clamp;
    logic                sat_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sat_q <= 1'b0;
        end else if (clear_fire) begin
            sat_q <= 1'b0;
        end else if (wr_fire && (|lane_clamp)) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_o = sat_q;
`else
    assign sat_o = 1'b0;
`endif

    for (genvar k = 0; k < NUM_COLS; k++) begin : g_lane
        logic signed [IN_W-1:0]  din;
        logic signed [ACC_W-1:0] ext;
        logic signed [ACC_W-1:0] cur;
        logic signed [ACC_W-1:0] acc_val;
        logic [AW-1:0]           rd_row;
        logic [ACC_W-1:0]        rd_q;

        assign din = wr_data_i[k*IN_W +: IN_W];
        assign ext = ACC_W'(din);
        assign cur = mem[wr_addr_i][k];

`ifdef ACC_SATURATE_EN
        // One guard bit: the two top sum bits differ exactly when the lane overflowed.
        logic signed [ACC_W:0] sum;
        logic                  ovf;

        assign sum     = {cur[ACC_W-1], cur} + {ext[ACC_W-1], ext};
        assign ovf     = sum[ACC_W] ^ sum[ACC_W-1];
        assign acc_val = !ovf ? sum[ACC_W-1:0] : (sum[ACC_W] ? ACC_MIN : ACC_MAX);
        assign lane_clamp[k] = wr_acc_i & ovf;
`else
        assign acc_val = cur + ext;
`endif

        assign lane_nxt[k] = wr_acc_i ? acc_val : ext;

        // Diagonal skew: lane k looks k rows back, wrapping modulo DEPTH.
        assign rd_row = rd_mode_i ? (rd_addr_i - AW'(k)) : rd_addr_i;

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                rd_q <= '0;
            end else if (rd_fire) begin
                rd_q <= mem[rd_row][k];
            end
        end

        assign rd_data_o[k*ACC_W +: ACC_W] = rd_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
        end
    end

endmodule
